alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//   Upstream stage of the structural ALU. Captures operands (A 4b, B 2b) and
//   op select (00 MUL, 01 SUB, 10 AND, 11 XOR) from board switches on a
//   debounced load button, then holds them stable on registered outputs.
//   Pulses op_valid one cycle after each new operand set so downstream logic
//   can sample the ALU result and flags (Y, Z, N, C, V).
// PARAMETERS
//   SYNC_STAGES      2   synchronizer flops per button input (>=2)
//   DEBOUNCE_CYCLES  4   stable cycles required to accept a level change (board: 500000)
//   AUTO_PERIOD      8   cycles between auto steps (used only with AUTO_CYCLE_EN)
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   rst_n        in   1  asynchronous reset, active-low
//   sw_a         in   4  operand A switches, sampled only at capture
//   sw_b         in   2  operand B switches, sampled only at capture
//   sw_sel       in   2  op select switches, sampled only at manual capture
//   btn_load     in   1  raw load button, asynchronous, active-high
//   btn_auto     in   1  raw auto-mode toggle button; ignored without AUTO_CYCLE_EN
//   A            out  4  registered operand A to ALU
//   B            out  2  registered operand B to ALU
//   sel          out  2  registered op select to ALU
//   op_valid     out  1  1-cycle pulse, cycle after A/B/sel update
//   busy         out  1  high while any debounce counter is nonzero
//   auto_active  out  1  high while in AUTO state
// BEHAVIOUR
// - Reset (async): A=0, B=0, sel=00, op_valid=0, busy=0, auto_active=0.
//   Synchronizers, debounced levels and counters clear to 0. FSM goes to IDLE.
// - Each button passes through SYNC_STAGES flops to give s.
//   Counter increments while s != debounced level db and clears when they match.
//   When the counter reaches DEBOUNCE_CYCLES-1 with s still differing, db<=s and
//   the counter clears. A press is the db rising edge (db & ~db_q).
// - Latency: A/B/sel update on rising edge number SYNC_STAGES+DEBOUNCE_CYCLES+1,
//   counted from the first edge that samples btn_load=1 stable.
//   op_valid is high for exactly the next cycle.
// - FSM states:
//   IDLE: load press -> CAPTURE.
//   CAPTURE: at entry edge, A<=sw_a, B<=sw_b, sel<=sw_sel. Next state VALID.
//   VALID: op_valid=1 for 1 cycle. Next state WAIT_REL.
//   WAIT_REL: waits for db_load=0, then IDLE. No capture while held.
// - A/B/sel never change outside a capture. Switch changes between presses
//   are ignored.
// - Bounce shorter than DEBOUNCE_CYCLES produces no capture and no op_valid.
// - A button still held at reset release counts as one press once debounced.
// - Reset during any state aborts the operation. No op_valid is emitted for
//   the aborted capture.
// - If load and auto presses land in the same cycle, load wins and the auto
//   press is dropped.
// CONFIGURATION
// - AUTO_CYCLE_EN defined:
//   * In IDLE, an auto press -> AUTO with auto_active=1. A<=sw_a, B<=sw_b,
//     sel<=00, op_valid pulses next cycle.
//   * Every AUTO_PERIOD cycles: sel increments 00->01->10->11->00 (wraps),
//     A/B are re-sampled, op_valid pulses 1 cycle after the step.
//   * A further auto press -> IDLE with sel held.
//   * A load press -> CAPTURE (manual capture), auto_active=0.
// - AUTO_CYCLE_EN undefined: no AUTO state. btn_auto is unused;
//   auto_active is tied 0. Auto-related counter and debouncer are not built.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, AUTO_PERIOD=8)
// 1. rst_n=0 for 3 cycles with random switches
//    -> A=0000, B=00, sel=00, op_valid=0, busy=0, auto_active=0.
// 2. sw_a=0101, sw_b=01, sw_sel=11, btn_load held 12 cycles
//    -> A=0101, B=01, sel=11 at edge 7; exactly one op_valid pulse at cycle 8.
// 3. btn_load 1,0,1,0 (1 cycle each), then held 1
//    -> no update during bounce, busy=1; a single capture 7 edges after the
//    final rise.
// 4. After test 2, release button, set sw_a=1111, sw_sel=00, wait 20 cycles
//    -> A=0101, sel=11 unchanged, op_valid=0.
// 5. btn_load held, rst_n=0 at edge 4, released at edge 6
//    -> outputs 0 during reset; capture 7 edges after reset release; one pulse.
// 6. [AUTO_CYCLE_EN] sw_a=1111, sw_b=11, auto press
//    -> sel 00,01,10,11,00 at 8-cycle spacing with op_valid each step;
//    a load press gives auto_active=0 and a manual capture.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: debounced capture of ALU operands and op select from board switches.
// Optional auto-cycle mode (sel sweeps 00..11) is built only when AUTO_CYCLE_EN is defined.
//
// state    | meaning
// IDLE     | waiting for a load (or auto) press
// CAPTURE  | operands latched on entry edge
// VALID    | op_valid high for this one cycle
// WAIT_REL | load button still held, no recapture until released
// AUTO     | sel stepped every AUTO_PERIOD cycles, operands resampled each step

module alu_operand_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_a,
    input  logic [1:0] sw_b,
    input  logic [1:0] sw_sel,
    input  logic       btn_load,
    input  logic       btn_auto,
    output logic [3:0] A,
    output logic [1:0] B,
    output logic [1:0] sel,
    output logic       op_valid,
    output logic       busy,
    output logic       auto_active
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_CYCLE_EN
    localparam int NB = 2;
    localparam int TW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [TW-1:0] TMR_TC = TW'(AUTO_PERIOD - 1);
`else
    localparam int NB = 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_VALID,
`ifdef AUTO_CYCLE_EN
        S_AUTO,
`endif
        S_WAIT_REL
    } state_t;

    state_t r_state;

    logic [NB-1:0][SYNC_STAGES-1:0] r_sync;
    logic [NB-1:0][CW-1:0]          r_cnt;
    logic [NB-1:0]                  r_db;
    logic [NB-1:0]                  r_db_q;
    logic [NB-1:0]                  w_btn;
    logic [NB-1:0]                  w_press;
    logic                           w_press_load;
    logic                           w_db_load;

    logic [3:0] r_a;
    logic [1:0] r_b;
    logic [1:0] r_sel;
    logic       r_op_valid;

`ifdef AUTO_CYCLE_EN
    logic          r_auto_active;
    logic          r_pend;
    logic [TW-1:0] r_timer;
    logic          w_press_auto;

    assign w_btn        = {btn_auto, btn_load};
    assign w_press_auto = w_press[1];
`else
    logic w_unused_auto;

    assign w_btn         = btn_load;
    assign w_unused_auto = btn_auto;
`endif

    assign w_press      = r_db & ~r_db_q;
    assign w_press_load = w_press[0];
    assign w_db_load    = r_db[0];

    // Bit 0 is the load button, bit 1 (when built) the auto button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= '0;
            r_db_q <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_btn[i]};
                r_db_q[i] <= r_db[i];
                if (r_sync[i][SYNC_STAGES-1] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_TC) begin
                    r_db[i]  <= r_sync[i][SYNC_STAGES-1];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sel      <= '0;
            r_op_valid <= 1'b0;
`ifdef AUTO_CYCLE_EN
            r_auto_active <= 1'b0;
            r_pend        <= 1'b0;
            r_timer       <= '0;
`endif
        end else begin
            r_op_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_press_load) begin
                        r_state <= S_CAPTURE;
                        r_a     <= sw_a;
                        r_b     <= sw_b;
                        r_sel   <= sw_sel;
                    end
`ifdef AUTO_CYCLE_EN
                    else if (w_press_auto) begin
                        r_state       <= S_AUTO;
                        r_auto_active <= 1'b1;
                        r_a           <= sw_a;
                        r_b           <= sw_b;
                        r_sel         <= 2'b00;
                        r_pend        <= 1'b1;
                        r_timer       <= TMR_TC;
                    end
`endif
                end
                S_CAPTURE: begin
                    r_state    <= S_VALID;
                    r_op_valid <= 1'b1;
                end
                S_VALID: begin
                    r_state <= S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!w_db_load) begin
                        r_state <= S_IDLE;
                    end
                end
`ifdef AUTO_CYCLE_EN
                S_AUTO: begin
                    r_op_valid <= r_pend;
                    r_pend     <= 1'b0;
                    if (w_press_load) begin
                        // A pending step pulse would now describe stale operands, so drop it.
                        r_op_valid    <= 1'b0;
                        r_state       <= S_CAPTURE;
                        r_auto_active <= 1'b0;
                        r_a           <= sw_a;
                        r_b           <= sw_b;
                        r_sel         <= sw_sel;
                    end else if (w_press_auto) begin
                        r_state       <= S_IDLE;
                        r_auto_active <= 1'b0;
                    end else if (r_timer == '0) begin
                        r_timer <= TMR_TC;
                        r_sel   <= r_sel + 2'd1;
                        r_a     <= sw_a;
                        r_b     <= sw_b;
                        r_pend  <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign A        = r_a;
    assign B        = r_b;
    assign sel      = r_sel;
    assign op_valid = r_op_valid;
    assign busy     = |r_cnt;
`ifdef AUTO_CYCLE_EN
    assign auto_active = r_auto_active;
`else
    assign auto_active = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer: vector table of captures plus bounce, reset-abort
// and auto-button sequences (auto-mode sequence only when AUTO_CYCLE_EN is defined).

module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_a;
    logic [1:0] sw_b;
    logic [1:0] sw_sel;
    logic       btn_load;
    logic       btn_auto;
    logic [3:0] A;
    logic [1:0] B;
    logic [1:0] sel;
    logic       op_valid;
    logic       busy;
    logic       auto_active;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int base;

    typedef struct {
        logic [3:0] a;
        logic [1:0] b;
        logic [1:0] s;
        logic [3:0] ea;
        logic [1:0] eb;
        logic [1:0] es;
    } vec_t;

    vec_t vecs[4];
    logic [3:0] prev_a;
    logic [1:0] prev_b;
    logic [1:0] prev_sel;
    logic [1:0] exp_sel;

    alu_operand_sequencer #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_a(sw_a),
        .sw_b(sw_b),
        .sw_sel(sw_sel),
        .btn_load(btn_load),
        .btn_auto(btn_auto),
        .A(A),
        .B(B),
        .sel(sel),
        .op_valid(op_valid),
        .busy(busy),
        .auto_active(auto_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (op_valid === 1'b1) pulse_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        vecs[0] = '{a: 4'b0101, b: 2'b01, s: 2'b11, ea: 4'b0101, eb: 2'b01, es: 2'b11};
        vecs[1] = '{a: 4'b1010, b: 2'b10, s: 2'b00, ea: 4'b1010, eb: 2'b10, es: 2'b00};
        vecs[2] = '{a: 4'b1111, b: 2'b11, s: 2'b01, ea: 4'b1111, eb: 2'b11, es: 2'b01};
        vecs[3] = '{a: 4'b0011, b: 2'b00, s: 2'b10, ea: 4'b0011, eb: 2'b00, es: 2'b10};

        rst_n    = 1'b0;
        btn_load = 1'b0;
        btn_auto = 1'b0;
        sw_a     = 4'($urandom_range(0, 15));
        sw_b     = 2'($urandom_range(0, 3));
        sw_sel   = 2'($urandom_range(0, 3));
        repeat (3) tick();
        chk("reset_A", A, 4'h0);
        chk("reset_B", B, 2'h0);
        chk("reset_sel", sel, 2'h0);
        chk("reset_op_valid", op_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_auto_active", auto_active, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();

        prev_a = 4'h0; prev_b = 2'h0; prev_sel = 2'h0;
        for (int i = 0; i < 4; i++) begin
            sw_a = vecs[i].a; sw_b = vecs[i].b; sw_sel = vecs[i].s;
            btn_load = 1'b1;
            base = pulse_cnt;
            repeat (4) tick();
            chk("busy_during_debounce", busy, 1'b1);
            repeat (2) tick();
            chk("hold_A_edge6", A, prev_a);
            chk("hold_sel_edge6", sel, prev_sel);
            tick();
            chk("cap_A_edge7", A, vecs[i].ea);
            chk("cap_B_edge7", B, vecs[i].eb);
            chk("cap_sel_edge7", sel, vecs[i].es);
            chk("op_valid_low_edge7", op_valid, 1'b0);
            tick();
            chk("op_valid_high_edge8", op_valid, 1'b1);
            tick();
            chk("op_valid_low_edge9", op_valid, 1'b0);
            btn_load = 1'b0;
            sw_a = ~sw_a; sw_b = ~sw_b; sw_sel = ~sw_sel;
            repeat (20) tick();
            chk("stable_A_after_release", A, vecs[i].ea);
            chk("stable_B_after_release", B, vecs[i].eb);
            chk("stable_sel_after_release", sel, vecs[i].es);
            chk("single_pulse", pulse_cnt - base, 1);
            chk("idle_busy", busy, 1'b0);
            prev_a = vecs[i].ea; prev_b = vecs[i].eb; prev_sel = vecs[i].es;
        end

        // Bounce: 1,0,1,0 then held; final rise is sampled on edge 5.
        sw_a = 4'b1001; sw_b = 2'b01; sw_sel = 2'b11;
        base = pulse_cnt;
        btn_load = 1'b1; tick();
        btn_load = 1'b0; tick();
        btn_load = 1'b1; tick();
        chk("bounce_busy", busy, 1'b1);
        btn_load = 1'b0; tick();
        btn_load = 1'b1;
        repeat (6) tick();
        chk("bounce_no_update_A", A, prev_a);
        chk("bounce_no_pulse", pulse_cnt - base, 0);
        tick();
        chk("bounce_cap_A", A, 4'b1001);
        chk("bounce_cap_sel", sel, 2'b11);
        repeat (2) tick();
        chk("bounce_single_pulse", pulse_cnt - base, 1);
        btn_load = 1'b0;
        repeat (20) tick();
        prev_a = 4'b1001; prev_sel = 2'b11;

        // Reset while load is held: aborted capture, then one capture after release.
        sw_a = 4'b0110; sw_b = 2'b10; sw_sel = 2'b01;
        base = pulse_cnt;
        btn_load = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_A_zero", A, 4'h0);
        chk("abort_sel_zero", sel, 2'h0);
        repeat (2) tick();
        chk("abort_busy_zero", busy, 1'b0);
        chk("abort_op_valid_zero", op_valid, 1'b0);
        rst_n = 1'b1;
        repeat (6) tick();
        chk("postreset_hold_A", A, 4'h0);
        chk("abort_no_pulse", pulse_cnt - base, 0);
        tick();
        chk("postreset_cap_A", A, 4'b0110);
        chk("postreset_cap_B", B, 2'b10);
        chk("postreset_cap_sel", sel, 2'b01);
        repeat (2) tick();
        chk("postreset_single_pulse", pulse_cnt - base, 1);
        btn_load = 1'b0;
        repeat (20) tick();

`ifdef AUTO_CYCLE_EN
        sw_a = 4'b1111; sw_b = 2'b11; sw_sel = 2'b01;
        base = pulse_cnt;
        btn_auto = 1'b1;
        repeat (7) tick();
        chk("auto_entry_active", auto_active, 1'b1);
        chk("auto_entry_sel", sel, 2'b00);
        chk("auto_entry_A", A, 4'b1111);
        chk("auto_entry_B", B, 2'b11);
        exp_sel = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            repeat (8) tick();
            exp_sel = exp_sel + 2'd1;
            chk("auto_step_sel", sel, exp_sel);
            chk("auto_step_pulses", pulse_cnt - base, k);
        end
        btn_auto = 1'b0;
        sw_a = 4'b0110; sw_b = 2'b10; sw_sel = 2'b10;
        btn_load = 1'b1;
        repeat (7) tick();
        chk("auto_load_inactive", auto_active, 1'b0);
        chk("auto_load_A", A, 4'b0110);
        chk("auto_load_B", B, 2'b10);
        chk("auto_load_sel", sel, 2'b10);
        tick();
        chk("auto_load_op_valid", op_valid, 1'b1);
        btn_load = 1'b0;
        repeat (20) tick();
        chk("auto_load_sel_held", sel, 2'b10);

        sw_a = 4'b1100; sw_b = 2'b01; sw_sel = 2'b11;
        btn_load = 1'b1; btn_auto = 1'b1;
        repeat (7) tick();
        chk("both_press_load_wins", auto_active, 1'b0);
        chk("both_press_sel", sel, 2'b11);
        chk("both_press_A", A, 4'b1100);
        btn_load = 1'b0; btn_auto = 1'b0;
        repeat (20) tick();
        chk("both_press_stays_manual", auto_active, 1'b0);
`else
        sw_a = 4'b1110; sw_b = 2'b01; sw_sel = 2'b00;
        base = pulse_cnt;
        btn_auto = 1'b1;
        repeat (15) tick();
        chk("auto_ignored_A", A, 4'b0110);
        chk("auto_ignored_sel", sel, 2'b01);
        chk("auto_ignored_pulses", pulse_cnt - base, 0);
        chk("auto_ignored_active", auto_active, 1'b0);
        chk("auto_ignored_busy", busy, 1'b0);
        btn_auto = 1'b0;
        repeat (3) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
